// File: rtl/fc_pkg.sv
// Types and constants shared by the FC bias buffer, FC datapath and result serializer.
package fc_pkg;

  localparam int FC_DATA_WIDTH = 16;
  localparam int FC_BATCH_SIZE = 16;

  typedef logic [FC_DATA_WIDTH-1:0] fc_word_t;
  typedef fc_word_t fc_batch_t [FC_BATCH_SIZE];

  typedef enum logic {
    SER_IDLE   = 1'b0,
    SER_STREAM = 1'b1
  } ser_state_e;

endpackage

// File: rtl/fc_result_serializer.sv
// Collects a parallel batch of FC results into a circular buffer and streams them
// out one word per cycle on valid/ready, flagging the last word of each layer.
//
// state      | meaning
// SER_IDLE   | output register empty (m_valid=0)
// SER_STREAM | output register holds a word (m_valid=1)
module fc_result_serializer
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH = FC_DATA_WIDTH,
  parameter int DEPTH      = 64,
  parameter int BATCH_SIZE = FC_BATCH_SIZE,
  parameter int LAYER_SIZE = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    batch_valid,
  output logic                    batch_ready,
  input  logic [DATA_WIDTH-1:0]   batch_data [BATCH_SIZE],
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic                    m_last,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic                    overflow_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = (LAYER_SIZE > 1) ? $clog2(LAYER_SIZE) : 1;

  logic [DATA_WIDTH-1:0] ram [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [LW-1:0]         word_cnt;
  ser_state_e            state;
  ser_state_e            state_nxt;
  logic                  write;
  logic                  load;
  logic                  layer_end;

  // Depends only on registered count, so m_ready never reaches batch_ready.
  assign batch_ready = (CW'(DEPTH) - count) >= CW'(BATCH_SIZE);
  assign write       = batch_valid && batch_ready;
  assign load        = (!m_valid || m_ready) && (count != '0);
  assign m_valid     = (state == SER_STREAM);
  assign occupancy   = count + CW'(m_valid);
  assign layer_end   = (word_cnt == LW'(LAYER_SIZE - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= SER_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SER_IDLE:   if (load) state_nxt = SER_STREAM;
      SER_STREAM: if (m_ready && !load) state_nxt = SER_IDLE;
      default:    state_nxt = SER_IDLE;
    endcase
  end

  // A batch always lands in free slots, so it never overlaps the word at rd_ptr.
  always_ff @(posedge clk) begin
    if (write) begin
      for (int i = 0; i < BATCH_SIZE; i++) begin
        ram[wr_ptr + PW'(i)] <= batch_data[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      word_cnt     <= '0;
      m_data       <= '0;
      m_last       <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      if (write) wr_ptr <= wr_ptr + PW'(BATCH_SIZE);
      if (batch_valid && !batch_ready) overflow_err <= 1'b1;
      if (load) begin
        m_data   <= ram[rd_ptr];
        m_last   <= layer_end;
        rd_ptr   <= rd_ptr + PW'(1);
        word_cnt <= layer_end ? '0 : word_cnt + LW'(1);
      end
      count <= count + (write ? CW'(BATCH_SIZE) : CW'(0)) - CW'(load);
    end
  end

endmodule
